// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle execute unit with a bit-serial shifter
// Logic/arith/compare ops resolve at accept; shifts step a working register one bit per cycle.
module seq_alu #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] shift_res;
  logic [SHW-1:0]   shamt;
  logic             is_shift;
  logic             is_illegal;

  assign shamt      = src_b[SHW-1:0];
  assign is_shift   = (alu_control == OP_SLL) || (alu_control == OP_SRA) || (alu_control == OP_SRL);
  assign is_illegal = (alu_control > OP_SLTU);

  always_comb begin
    alu_res = '0;
    case (alu_control)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      default: alu_res = '0;
    endcase
  end

  // One-bit step of the latched shift op; sra copies the running sign bit.
  always_comb begin
    shift_res = '0;
    case (op_q)
      OP_SLL:  shift_res = {work_q[WIDTH-2:0], 1'b0};
      OP_SRA:  shift_res = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: shift_res = {1'b0, work_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_illegal) begin
            result_d  = '0;
            zero_d    = 1'b1;
            illegal_d = 1'b1;
            state_d   = DONE;
          end else if (is_shift && (shamt != '0)) begin
            work_d  = src_a;
            op_d    = alu_control;
            cnt_d   = shamt;
            state_d = SHIFT;
          end else if (is_shift) begin
            result_d  = src_a;
            zero_d    = (src_a == '0);
            illegal_d = 1'b0;
            state_d   = DONE;
          end else begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = 1'b0;
            state_d   = DONE;
          end
        end
      end
      SHIFT: begin
        work_d = shift_res;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d  = shift_res;
          zero_d    = (shift_res == '0);
          illegal_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu
// Directed cases plus random ops compared against an arithmetic reference model.
module tb_seq_alu;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal     (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    int k;
    k   = int'(b[4:0]);
    ill = 1'b0;
    lat = 1;
    case (c)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: r = a << k;
      4'd7: r = $signed(a) >>> k;
      4'd8: r = a >> k;
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
      default: begin r = 32'd0; ill = 1'b1; end
    endcase
    if (c == 4'd6 || c == 4'd7 || c == 4'd8) lat = k + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input string tag);
    logic [31:0] er;
    logic        eill;
    int          elat;
    int          lat;
    model(c, a, b, er, eill, elat);
    wait_ready(tag);
    alu_control = c;
    src_a       = a;
    src_b       = b;
    in_valid    = 1'b1;
    tick();
    in_valid    = 1'b0;
    alu_control = 4'($urandom);
    src_a       = $urandom;
    src_b       = $urandom;
    lat = 1;
    while (!out_valid && lat <= 64) begin
      check({tag, "_busy_in_ready"}, in_ready, 0);
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, elat);
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_done_in_ready"}, in_ready, 0);
    check({tag, "_result"}, result, er);
    check({tag, "_zero"}, zero, (er == 32'd0));
    check({tag, "_illegal"}, illegal, eill);
    repeat (hold) begin
      tick();
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_result"}, result, er);
      check({tag, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_retired_valid"}, out_valid, 0);
    check({tag, "_retired_in_ready"}, in_ready, 1);
    check({tag, "_retired_result"}, result, er);
  endtask

  initial begin
    logic seen;
    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    alu_control = 4'd0;
    src_a       = 32'd0;
    src_b       = 32'd0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_illegal", illegal, 0);
    reset = 1'b0;

    run_op(4'd0, 32'h0000_0005, 32'hFFFF_FFFB, 0, "add");
    run_op(4'd5, 32'hFFFF_FFFF, 32'h0000_0001, 0, "slt");
    run_op(4'd9, 32'hFFFF_FFFF, 32'h0000_0001, 0, "sltu");
    run_op(4'd7, 32'h8000_0000, 32'd31, 0, "sra31");
    run_op(4'd8, 32'h8000_0000, 32'd31, 0, "srl31");
    run_op(4'd6, 32'h0000_0001, 32'd0, 0, "sll0");

    // Backpressure with a competing request held during DONE.
    wait_ready("bp");
    alu_control = 4'd1; src_a = 32'd10; src_b = 32'd3; in_valid = 1'b1;
    tick();
    alu_control = 4'd0; src_a = 32'd100; src_b = 32'd23;
    repeat (5) begin
      check("bp_valid", out_valid, 1);
      check("bp_result", result, 32'd7);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_handoff_valid", out_valid, 0);
    check("bp_handoff_in_ready", in_ready, 1);
    check("bp_handoff_result", result, 32'd7);
    tick();
    in_valid = 1'b0;
    check("bp_second_valid", out_valid, 1);
    check("bp_second_result", result, 32'd123);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_second_retired", out_valid, 0);

    run_op(4'd12, 32'h0000_1234, 32'd0, 1, "illegal");
    run_op(4'd4, 32'h0000_F0F0, 32'h0000_0FF0, 0, "xor");

    // Reset in the middle of a long shift discards it.
    wait_ready("rs");
    alu_control = 4'd6; src_a = $urandom | 32'd1; src_b = 32'd20; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("rs_shift_in_ready", in_ready, 0);
    check("rs_shift_valid", out_valid, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rs_in_ready", in_ready, 1);
    check("rs_out_valid", out_valid, 0);
    check("rs_result", result, 0);
    check("rs_zero", zero, 0);
    check("rs_illegal", illegal, 0);
    seen = 1'b0;
    repeat (25) begin
      tick();
      seen = seen | out_valid;
    end
    check("rs_no_stale_valid", seen, 0);
    run_op(4'd2, 32'h0000_00FF, 32'h0000_000F, 0, "and");

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      if (i % 10 == 0) a = 32'h8000_0000;
      if (i % 13 == 0) b = a;
      run_op(4'($urandom_range(0, 15)), a, b, $urandom_range(0, 3), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Multi-cycle execute unit; the consumer end of the 4-bit ALUControl interface driven by the ALU decoder.
- Accepts one operation through a valid/ready handshake.
  - Logic, arithmetic and compare ops resolve in 1 cycle.
  - Shifts iterate 1 bit per cycle.
- Presents the result through a valid/ready handshake.
- Sits between decode/operand-fetch and writeback in the multi-cycle datapath.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of 2, >= 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept an operation (IDLE only).
- alu_control  input  4  operation code, encoding below.
- src_a  input  WIDTH  operand A.
- src_b  input  WIDTH  operand B; shifts use src_b[SHW-1:0] as shamt.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- illegal  output  1  alu_control was an unassigned code.

Behaviour:
- Encoding:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor.
  - 0101 slt (signed), 0110 sll, 0111 sra, 1000 srl, 1001 sltu.
  - 1010-1111 illegal.
- Arithmetic:
  - add/sub are modulo 2^WIDTH; carry and overflow are discarded.
  - slt/sltu give result = {WIDTH-1 zeros, lt}.
  - sra replicates the sign bit of the running value.
- Reset: synchronous. On the next edge:
  - state = IDLE; in_ready = 1; out_valid = 0.
  - result = 0, zero = 0, illegal = 0.
  - Any in-flight operation is discarded with no output.
- States: IDLE, SHIFT, DONE.
- IDLE (in_ready = 1). An op is accepted on an edge with in_valid = 1.
  - Non-shift or illegal op: result/zero/illegal are registered this edge; go to DONE. out_valid is high the next cycle (latency 1).
  - Shift with shamt = 0: result = src_a; go to DONE (latency 1).
  - Shift with shamt = k > 0:
    - Latch src_a into the working register, the op, and count = k; go to SHIFT.
    - Each SHIFT cycle shifts the working register 1 bit and decrements count.
    - When count reaches 1, the final shift is performed, result is registered, and the state goes to DONE.
    - out_valid asserts k+1 cycles after the accept edge.
- SHIFT: in_ready = 0; in_valid is ignored; result is not updated externally until DONE.
- DONE:
  - out_valid = 1; result/zero/illegal are held stable while out_valid = 1 and out_ready = 0.
  - On an edge with out_ready = 1: go to IDLE and drop out_valid. result holds its last value.
  - No bypass: a new op is accepted at the earliest on the edge after the handoff. Minimum initiation interval is 2 cycles.
- Illegal op: result = 0, zero = 1, illegal = 1, latency 1. illegal clears on the next accepted legal op.
- in_valid during SHIFT or DONE is not accepted. The source must hold the op until in_ready; the unit does not latch it early.
- Inputs are sampled only on the accept edge. Later changes to src_a, src_b or alu_control do not affect an in-flight op.
- out_ready is ignored outside DONE.
- Reset while in DONE with out_valid = 1: out_valid drops on that edge and the result is lost.
- Reset has priority over all handshakes.

Test Plan:
- Reset, then add 0x00000005 + 0xFFFFFFFB with out_ready = 1 -> out_valid 1 cycle after accept; result 0x00000000, zero = 1, illegal = 0; in_ready back high the following cycle.
- Signed vs unsigned compare, A = 0xFFFFFFFF, B = 0x00000001 -> slt gives result 0x00000001; sltu gives result 0x00000000, zero = 1.
- Shifts:
  - sra A = 0x80000000, shamt = 31 -> out_valid exactly 32 cycles after accept; result 0xFFFFFFFF; in_ready low throughout.
  - srl with the same operands -> result 0x00000001.
  - sll A = 0x1, shamt = 0 -> latency 1, result 0x00000001.
- Backpressure:
  - Sub 10 - 3 with out_ready = 0 for 5 cycles -> out_valid and result 0x00000007 stable all 5 cycles; in_ready = 0.
  - A second in_valid during those cycles is not accepted; it is accepted only on the edge after out_ready = 1 retires the first op.
- alu_control = 1100, A = 0x1234 -> result 0, zero = 1, illegal = 1.
  - A following xor 0xF0F0 ^ 0x0FF0 gives 0x0000FF00 with illegal = 0.
- Assert reset during SHIFT (sll, shamt = 20, cycle 6) -> next edge: in_ready = 1, out_valid = 0, result = 0; no out_valid for the aborted op.
  - A new and 0xFF & 0x0F completes normally with 0x0000000F.
